nibble_serial_adder: RTL and testbench



---
 rtl/nibble_adder_pkg.sv | 18 +
 rtl/nibble_cla.sv | 34 +++
 rtl/nibble_serial_adder.sv | 150 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types, constants and helpers for the nibble-serial adder.
// FSM state encoding, nibble width and the two's-complement overflow rule.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Overflow when both operands share a sign and the result sign differs.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_cla.sv
// Combinational 4-bit carry-lookahead adder; every carry is a flat
// generate/propagate expression so no carry ripples through another.
module nibble_cla
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign g[gi] = a[gi] & b[gi];
            assign p[gi] = a[gi] ^ b[gi];
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign co   = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one nibble CLA, least-significant nibble first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add a 'sub' port for a-b.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic               carry_reg, carry_next;
    logic               a_msb_reg, a_msb_next;
    logic               b_msb_reg, b_msb_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               cout_reg, cout_next;
    logic               ovf_reg, ovf_next;

    logic               sub_eff;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [NIBBLE_W-1:0] cla_s;
    logic               cla_co;
    logic [WIDTH-1:0]   work_shift;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so the stored B and the initial carry change.
    assign b_eff   = sub_eff ? ~b : b;
    assign cin_eff = sub_eff ? 1'b1 : cin;

    nibble_cla u_cla (
        .a  (a_sh_reg[NIBBLE_W-1:0]),
        .b  (b_sh_reg[NIBBLE_W-1:0]),
        .ci (carry_reg),
        .s  (cla_s),
        .co (cla_co)
    );

    // New sum nibble enters at the top; after NIBBLES shifts the word is aligned.
    assign work_shift = WIDTH'({cla_s, work_reg} >> NIBBLE_W);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        work_next  = work_reg;
        carry_next = carry_reg;
        a_msb_next = a_msb_reg;
        b_msb_next = b_msb_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b_eff;
                    carry_next = cin_eff;
                    a_msb_next = a[WIDTH-1];
                    b_msb_next = b_eff[WIDTH-1];
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next  = a_sh_reg >> NIBBLE_W;
                b_sh_next  = b_sh_reg >> NIBBLE_W;
                work_next  = work_shift;
                carry_next = cla_co;
                idx_next   = idx_reg + IDX_W'(1);
                if (idx_reg == LAST_IDX) begin
                    // Results load on the edge entering DONE so they line up with done.
                    sum_next   = work_shift;
                    cout_next  = cla_co;
                    ovf_next   = calc_ovf(a_msb_reg, b_msb_reg, work_shift[WIDTH-1]);
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            work_reg  <= work_next;
            carry_reg <= carry_next;
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit and a 4-bit instance
// share clock and reset; expected values are hand-computed constants.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        sub16 = 1'b0;
    logic        ready16, cout16, ovf16, done16;
    logic [15:0] sum16;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        cin4 = 1'b0;
    logic        sub4 = 1'b0;
    logic        ready4, cout4, ovf4, done4;
    logic [3:0]  sum4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub   (sub16),
`endif
        .ready (ready16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16),
        .done  (done16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub   (sub4),
`endif
        .ready (ready4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4),
        .done  (done4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Launch one 16-bit op and wait for done; returns the cycle it appeared in.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_op, input logic tc,
                         input logic ts, output int lat);
        @(negedge clk);
        a16 = ta; b16 = tb_op; cin16 = tc; sub16 = ts; start16 = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start16 = 1'b0;
        end while (!done16 && lat < 20);
        if (!done16) check_eq("done16_timeout", 32'(done16), 32'd1);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_op, input logic tc,
                        input logic ts, output int lat);
        @(negedge clk);
        a4 = ta; b4 = tb_op; cin4 = tc; sub4 = ts; start4 = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start4 = 1'b0;
        end while (!done4 && lat < 20);
        if (!done4) check_eq("done4_timeout", 32'(done4), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ndone;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_ready", 32'(ready16), 32'd1);
        check_eq("rst_done", 32'(done16), 32'd0);
        check_eq("rst_sum", 32'(sum16), 32'd0);
        check_eq("rst_cout", 32'(cout16), 32'd0);
        check_eq("rst_ovf", 32'(ovf16), 32'd0);

        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        check_eq("wrap_lat", 32'(lat), 32'd5);
        check_eq("wrap_sum", 32'(sum16), 32'h0000);
        check_eq("wrap_cout", 32'(cout16), 32'd1);
        check_eq("wrap_ovf", 32'(ovf16), 32'd0);
        check_eq("wrap_ready_in_done", 32'(ready16), 32'd0);
        @(negedge clk);
        check_eq("wrap_done_1cyc", 32'(done16), 32'd0);
        check_eq("wrap_ready_after", 32'(ready16), 32'd1);

        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        check_eq("povf_sum", 32'(sum16), 32'h8000);
        check_eq("povf_cout", 32'(cout16), 32'd0);
        check_eq("povf_ovf", 32'(ovf16), 32'd1);

        run16(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
        check_eq("cin_lat", 32'(lat), 32'd5);
        check_eq("cin_sum", 32'(sum16), 32'h5556);
        check_eq("cin_cout", 32'(cout16), 32'd0);
        check_eq("cin_ovf", 32'(ovf16), 32'd0);

        // Abort an op with rst in its second RUN cycle.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_ready", 32'(ready16), 32'd1);
        check_eq("abort_sum", 32'(sum16), 32'd0);
        check_eq("abort_cout", 32'(cout16), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done16) ndone++;
        end
        check_eq("abort_no_done", 32'(ndone), 32'd0);

        run16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
        check_eq("fresh_sum", 32'(sum16), 32'h1000);
        check_eq("fresh_cout", 32'(cout16), 32'd0);

        // Keep start asserted through RUN and DONE with changing operands.
        @(negedge clk);
        a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("busy_ready_%0d", i), 32'(ready16), 32'd0);
            if (done16) ndone++;
            a16 = 16'hA5A5 ^ 16'(i);
            b16 = 16'h5A5A + 16'(i);
            start16 = (i < 4);
        end
        check_eq("busy_sum", 32'(sum16), 32'h0003);
        check_eq("busy_one_done", 32'(ndone), 32'd1);
        @(negedge clk);
        check_eq("busy_hold_sum", 32'(sum16), 32'h0003);
        check_eq("busy_hold_done", 32'(done16), 32'd0);

        // rst and start together: rst must win.
        @(negedge clk);
        rst = 1'b1; start16 = 1'b1; a16 = 16'h4444; b16 = 16'h4444;
        @(negedge clk);
        rst = 1'b0; start16 = 1'b0;
        check_eq("rst_start_ready", 32'(ready16), 32'd1);
        ndone = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (done16) ndone++;
        end
        check_eq("rst_start_no_done", 32'(ndone), 32'd0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        run16(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        check_eq("sub_neg_sum", 32'(sum16), 32'hFFFE);
        check_eq("sub_neg_cout", 32'(cout16), 32'd0);
        check_eq("sub_neg_ovf", 32'(ovf16), 32'd0);

        run16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        check_eq("sub_ovf_sum", 32'(sum16), 32'h7FFF);
        check_eq("sub_ovf_cout", 32'(cout16), 32'd1);
        check_eq("sub_ovf_ovf", 32'(ovf16), 32'd1);
`endif

        run4(4'h9, 4'h8, 1'b1, 1'b0, lat);
        check_eq("w4_lat", 32'(lat), 32'd2);
        check_eq("w4_sum", 32'(sum4), 32'h2);
        check_eq("w4_cout", 32'(cout4), 32'd1);
        check_eq("w4_ovf", 32'(ovf4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
